// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage definitions: FSM encoding, NOP word and IF/ID bundle widths.
package if_fetch_stage_pkg;

  localparam int unsigned IF_DATA_W   = 32;
  localparam int unsigned FETCH_CNT_W = 32;

  localparam logic [IF_DATA_W-1:0] IF_NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  // IF/ID payload as seen by the ID stage.
  typedef struct packed {
    logic [IF_DATA_W-1:0] pc;
    logic [IF_DATA_W-1:0] pc4;
    logic [IF_DATA_W-1:0] instr;
    logic                 valid;
  } ifid_t;

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a new instruction, insert a bubble, or hold.
module if_id_reg
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned          DATA_W    = IF_DATA_W,
  parameter logic [DATA_W-1:0]    NOP_INSTR = DATA_W'(IF_NOP_INSTR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              bubble_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] pc4_i,
  input  logic [DATA_W-1:0] instr_i,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] pc4_o,
  output logic [DATA_W-1:0] instr_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] pc_q, pc4_q, instr_q;
  logic              valid_q;

  // A bubble keeps the PC fields so the ID stage still sees a sane address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      pc4_q   <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (bubble_i) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (load_i) begin
      pc_q    <= pc_i;
      pc4_q   <= pc4_i;
      instr_q <= instr_i;
      valid_q <= 1'b1;
    end
  end

  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: imem req/ack handshake, PC stall generation, flush
// handling (including draining a killed in-flight request) and the IF/ID register.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned       DATA_W    = IF_DATA_W,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(IF_NOP_INSTR)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      PC_i,
  input  logic                   ID_Stall,
  input  logic                   Flush,
  output logic                   imem_req,
  output logic [DATA_W-1:0]      imem_addr,
  input  logic                   imem_ack,
  input  logic [DATA_W-1:0]      imem_rdata,
  output logic                   PC_Stall,
  output logic [DATA_W-1:0]      IFID_PC,
  output logic [DATA_W-1:0]      IFID_PC4,
  output logic [DATA_W-1:0]      IFID_Instr,
  output logic                   IFID_Valid,
  output logic [FETCH_CNT_W-1:0] FetchCnt
);

  fetch_state_e            state_q, state_d;
  logic [DATA_W-1:0]       buf_pc_q, buf_pc_d;
  logic [DATA_W-1:0]       buf_instr_q, buf_instr_d;
  logic [DATA_W-1:0]       drain_addr_q, drain_addr_d;
  logic [FETCH_CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;

  logic                    req_c;
  logic [DATA_W-1:0]       addr_c;
  logic                    stall_c;
  logic                    ifid_load_c;
  logic                    ifid_bubble_c;
  logic [DATA_W-1:0]       ifid_pc_c;
  logic [DATA_W-1:0]       ifid_instr_c;
  logic [DATA_W-1:0]       ifid_pc4_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_REQ;
      buf_pc_q     <= '0;
      buf_instr_q  <= NOP_INSTR;
      drain_addr_q <= '0;
      fetch_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      buf_pc_q     <= buf_pc_d;
      buf_instr_q  <= buf_instr_d;
      drain_addr_q <= drain_addr_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  // Flush outranks ack and ID_Stall in every state.
  always_comb begin
    state_d       = state_q;
    buf_pc_d      = buf_pc_q;
    buf_instr_d   = buf_instr_q;
    drain_addr_d  = drain_addr_q;
    fetch_cnt_d   = fetch_cnt_q;
    req_c         = 1'b0;
    addr_c        = PC_i;
    stall_c       = 1'b1;
    ifid_load_c   = 1'b0;
    ifid_bubble_c = 1'b0;
    ifid_pc_c     = PC_i;
    ifid_instr_c  = imem_rdata;

    case (state_q)
      ST_REQ: begin
        req_c  = 1'b1;
        addr_c = PC_i;
        if (Flush) begin
          ifid_bubble_c = 1'b1;
          stall_c       = 1'b0;
          if (!imem_ack) begin
            drain_addr_d = PC_i;
            state_d      = ST_DRAIN;
          end
        end else if (imem_ack && !ID_Stall) begin
          ifid_load_c = 1'b1;
          fetch_cnt_d = fetch_cnt_q + FETCH_CNT_W'(1);
          stall_c     = 1'b0;
        end else if (imem_ack) begin
          buf_pc_d    = PC_i;
          buf_instr_d = imem_rdata;
          state_d     = ST_HOLD;
        end else if (!ID_Stall) begin
          ifid_bubble_c = 1'b1;
        end
      end

      ST_HOLD: begin
        addr_c = buf_pc_q;
        if (Flush) begin
          ifid_bubble_c = 1'b1;
          stall_c       = 1'b0;
          buf_pc_d      = '0;
          buf_instr_d   = NOP_INSTR;
          state_d       = ST_REQ;
        end else if (!ID_Stall) begin
          ifid_load_c  = 1'b1;
          ifid_pc_c    = buf_pc_q;
          ifid_instr_c = buf_instr_q;
          fetch_cnt_d  = fetch_cnt_q + FETCH_CNT_W'(1);
          stall_c      = 1'b0;
          state_d      = ST_REQ;
        end
      end

      ST_DRAIN: begin
        // Keep the killed request stable until memory acks it, then drop the data.
        req_c         = 1'b1;
        addr_c        = drain_addr_q;
        ifid_bubble_c = 1'b1;
        if (Flush) begin
          stall_c = 1'b0;
        end else if (imem_ack) begin
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  assign ifid_pc4_c = ifid_pc_c + DATA_W'(4);

  assign imem_req  = req_c;
  assign imem_addr = addr_c;
  assign PC_Stall  = stall_c;
  assign FetchCnt  = fetch_cnt_q;

  if_id_reg #(
    .DATA_W    (DATA_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (reset),
    .load_i   (ifid_load_c),
    .bubble_i (ifid_bubble_c),
    .pc_i     (ifid_pc_c),
    .pc4_i    (ifid_pc4_c),
    .instr_i  (ifid_instr_c),
    .pc_o     (IFID_PC),
    .pc4_o    (IFID_PC4),
    .instr_o  (IFID_Instr),
    .valid_o  (IFID_Valid)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a delivery scoreboard keyed on FetchCnt.
module tb_if_fetch_stage;

  localparam logic [31:0] GARB = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC_i;
  logic        ID_Stall;
  logic        Flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        PC_Stall;
  logic [31:0] IFID_PC;
  logic [31:0] IFID_PC4;
  logic [31:0] IFID_Instr;
  logic        IFID_Valid;
  logic [31:0] FetchCnt;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] cnt_seen = 32'd0;

  if_fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .PC_i       (PC_i),
    .ID_Stall   (ID_Stall),
    .Flush      (Flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .PC_Stall   (PC_Stall),
    .IFID_PC    (IFID_PC),
    .IFID_PC4   (IFID_PC4),
    .IFID_Instr (IFID_Instr),
    .IFID_Valid (IFID_Valid),
    .FetchCnt   (FetchCnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic ack, input logic [31:0] rd,
                       input logic stall, input logic fl);
    @(negedge clk);
    PC_i       = pc;
    imem_ack   = ack;
    imem_rdata = rd;
    ID_Stall   = stall;
    Flush      = fl;
    #1;
  endtask

  task automatic expect_dlv(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  // Clock edge, then score any new delivery into IF/ID.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (FetchCnt !== cnt_seen) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_delivery", FetchCnt, cnt_seen);
      end else begin
        e = exp_q.pop_front();
        chk("dlv_pc", IFID_PC, e.pc);
        chk("dlv_pc4", IFID_PC4, e.pc + 32'd4);
        chk("dlv_instr", IFID_Instr, e.instr);
        chk("dlv_valid", 32'(IFID_Valid), 32'd1);
        chk("dlv_cnt", FetchCnt, cnt_seen + 32'd1);
      end
      cnt_seen = FetchCnt;
    end
  endtask

  initial begin
    reset = 1'b0; PC_i = '0; ID_Stall = 1'b0; Flush = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    #1;
    chk("rst_pc", IFID_PC, 32'd0);
    chk("rst_pc4", IFID_PC4, 32'd0);
    chk("rst_instr", IFID_Instr, 32'd0);
    chk("rst_valid", 32'(IFID_Valid), 32'd0);
    chk("rst_cnt", FetchCnt, 32'd0);
    chk("rst_req", 32'(imem_req), 32'd1);
    @(negedge clk);
    reset = 1'b1;

    // Zero-wait memory, one instruction per cycle.
    for (int i = 0; i < 3; i++) begin
      drive(32'(i * 4), 1'b1, rd_of(32'(i * 4)), 1'b0, 1'b0);
      chk("zw_stall", 32'(PC_Stall), 32'd0);
      chk("zw_addr", imem_addr, 32'(i * 4));
      expect_dlv(32'(i * 4), rd_of(32'(i * 4)));
      tick();
    end
    chk("zw_cnt", FetchCnt, 32'd3);

    // Two wait states at 0x10.
    for (int i = 0; i < 2; i++) begin
      drive(32'h10, 1'b0, GARB, 1'b0, 1'b0);
      chk("ws_stall", 32'(PC_Stall), 32'd1);
      chk("ws_req", 32'(imem_req), 32'd1);
      tick();
      chk("ws_bub_valid", 32'(IFID_Valid), 32'd0);
      chk("ws_bub_instr", IFID_Instr, 32'd0);
      chk("ws_bub_pc", IFID_PC, 32'h8);
    end
    drive(32'h10, 1'b1, rd_of(32'h10), 1'b0, 1'b0);
    chk("ws_ack_stall", 32'(PC_Stall), 32'd0);
    expect_dlv(32'h10, rd_of(32'h10));
    tick();
    chk("ws_pc4", IFID_PC4, 32'h14);
    chk("ws_cnt", FetchCnt, 32'd4);

    // Ack while ID stalled: buffer, HOLD, then release.
    drive(32'h20, 1'b1, rd_of(32'h20), 1'b1, 1'b0);
    chk("hold_enter_stall", 32'(PC_Stall), 32'd1);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(32'h20, 1'b0, GARB, 1'b1, 1'b0);
      chk("hold_req", 32'(imem_req), 32'd0);
      chk("hold_stall", 32'(PC_Stall), 32'd1);
      tick();
      chk("hold_ifid_pc", IFID_PC, 32'h10);
      chk("hold_ifid_valid", 32'(IFID_Valid), 32'd1);
    end
    drive(32'h20, 1'b0, GARB, 1'b0, 1'b0);
    chk("hold_rel_req", 32'(imem_req), 32'd0);
    chk("hold_rel_stall", 32'(PC_Stall), 32'd0);
    expect_dlv(32'h20, rd_of(32'h20));
    tick();
    drive(32'h24, 1'b1, rd_of(32'h24), 1'b0, 1'b0);
    chk("hold_next_addr", imem_addr, 32'h24);
    expect_dlv(32'h24, rd_of(32'h24));
    tick();

    // Flush while waiting at 0x30: drain the killed request.
    drive(32'h30, 1'b0, GARB, 1'b0, 1'b0);
    chk("fl_wait_stall", 32'(PC_Stall), 32'd1);
    tick();
    drive(32'h30, 1'b0, GARB, 1'b0, 1'b1);
    chk("fl_stall", 32'(PC_Stall), 32'd0);
    tick();
    chk("fl_bub_valid", 32'(IFID_Valid), 32'd0);
    drive(32'h100, 1'b0, GARB, 1'b0, 1'b0);
    chk("drain_addr", imem_addr, 32'h30);
    chk("drain_req", 32'(imem_req), 32'd1);
    chk("drain_stall", 32'(PC_Stall), 32'd1);
    tick();
    drive(32'h100, 1'b1, GARB, 1'b0, 1'b0);
    chk("drain_ack_addr", imem_addr, 32'h30);
    chk("drain_ack_stall", 32'(PC_Stall), 32'd1);
    tick();
    chk("drain_discard_valid", 32'(IFID_Valid), 32'd0);
    drive(32'h100, 1'b1, rd_of(32'h100), 1'b0, 1'b0);
    chk("post_drain_addr", imem_addr, 32'h100);
    expect_dlv(32'h100, rd_of(32'h100));
    tick();

    // Flush coinciding with ack: data discarded, stay in REQ.
    drive(32'h104, 1'b1, rd_of(32'h104), 1'b0, 1'b1);
    chk("fl_ack_stall", 32'(PC_Stall), 32'd0);
    tick();
    chk("fl_ack_valid", 32'(IFID_Valid), 32'd0);

    // Flush while holding a buffered instruction.
    drive(32'h180, 1'b1, rd_of(32'h180), 1'b1, 1'b0);
    tick();
    drive(32'h180, 1'b0, GARB, 1'b1, 1'b1);
    chk("fl_hold_req", 32'(imem_req), 32'd0);
    chk("fl_hold_stall", 32'(PC_Stall), 32'd0);
    tick();
    drive(32'h200, 1'b0, GARB, 1'b0, 1'b0);
    chk("fl_hold_req_addr", imem_addr, 32'h200);
    chk("fl_hold_req_on", 32'(imem_req), 32'd1);
    tick();

    // Enter DRAIN at 0x200, then async reset mid-request.
    drive(32'h200, 1'b0, GARB, 1'b0, 1'b1);
    tick();
    drive(32'h300, 1'b0, GARB, 1'b0, 1'b0);
    chk("pre_rst_drain_addr", imem_addr, 32'h200);
    reset = 1'b0;
    #1;
    chk("arst_pc", IFID_PC, 32'd0);
    chk("arst_pc4", IFID_PC4, 32'd0);
    chk("arst_valid", 32'(IFID_Valid), 32'd0);
    chk("arst_cnt", FetchCnt, 32'd0);
    chk("arst_addr", imem_addr, 32'h300);
    cnt_seen = 32'd0;
    reset = 1'b1;

    // Fetch at the top of the address space: PC+4 wraps.
    drive(32'hFFFF_FFFC, 1'b1, rd_of(32'hFFFF_FFFC), 1'b0, 1'b0);
    expect_dlv(32'hFFFF_FFFC, rd_of(32'hFFFF_FFFC));
    tick();
    chk("wrap_pc4", IFID_PC4, 32'h0000_0000);
    chk("wrap_cnt", FetchCnt, 32'd1);

    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
